// File: rtl/vending_pkg.sv
// Constants and state encoding shared by the vending machine front-panel blocks
// (debouncer, event flasher).
package vending_pkg;

  localparam int CLK_HZ             = 40000000;
  localparam int DEBOUNCE_CYCLES    = CLK_HZ / 50;
  localparam int DEFAULT_ON_CYCLES  = CLK_HZ / 4;
  localparam int DEFAULT_OFF_CYCLES = CLK_HZ / 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } flasher_state_t;

endpackage

// File: rtl/flash_timer.sv
// Loadable down-counter shared by the flash and gap phases; done is high
// combinationally whenever the count sits at zero.
module flash_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/event_flasher.sv
// Stretches one-cycle event strobes into fixed-length LED flashes, queueing
// events that arrive mid-flash and replaying them after a dark gap.
module event_flasher
  import vending_pkg::*;
#(
  parameter int ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES  = DEFAULT_OFF_CYCLES,
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = 24,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              event_pulse,
  input  logic              clear,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  flasher_state_t   state;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_enable;
  logic             timer_done;

  flash_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_enable),
    .done       (timer_done)
  );

  // A clear loads zero so the timer is parked exactly as after reset.
  always_comb begin
    timer_load   = 1'b0;
    timer_value  = '0;
    timer_enable = 1'b0;
    if (clear) begin
      timer_load = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (event_pulse) begin
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end
        end
        ON: begin
          if (timer_done) begin
            timer_load  = 1'b1;
            timer_value = OFF_LOAD;
          end else begin
            timer_enable = 1'b1;
          end
        end
        GAP: begin
          if (timer_done && (pending != '0 || event_pulse)) begin
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end else begin
            timer_enable = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // An event at the end of an empty gap restarts directly, as if from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      led      <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        led     <= 1'b0;
        pending <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (event_pulse) begin
              state <= ON;
              led   <= 1'b1;
            end
          end
          ON: begin
            if (event_pulse) begin
              if (pending == PEND_MAX) overflow <= 1'b1;
              else                     pending  <= pending + 1'b1;
            end
            if (timer_done) begin
              state <= GAP;
              led   <= 1'b0;
            end
          end
          GAP: begin
            if (timer_done) begin
              if (pending != '0) begin
                state <= ON;
                led   <= 1'b1;
                if (!event_pulse) pending <= pending - 1'b1;
              end else if (event_pulse) begin
                state <= ON;
                led   <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else if (event_pulse) begin
              if (pending == PEND_MAX) overflow <= 1'b1;
              else                     pending  <= pending + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_event_flasher.sv
// Directed and random stimulus for event_flasher, checked against a schedule
// model that tracks the start edge of every accepted flash.
module tb_event_flasher;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 2;
  localparam int MAX_P  = 3;
  localparam int PERIOD = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       event_pulse;
  logic       clear;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  int starts[$];

  logic       exp_led;
  logic       exp_busy;
  logic [1:0] exp_pend;
  logic       exp_ovf;

  event_flasher #(
    .ON_CYCLES   (ON_C),
    .OFF_CYCLES  (OFF_C),
    .MAX_PENDING (MAX_P),
    .CNT_W       (4),
    .PEND_W      (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .event_pulse (event_pulse),
    .clear       (clear),
    .led         (led),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic int count_after(input int e);
    int n = 0;
    foreach (starts[i]) if (starts[i] > e) n++;
    return n;
  endfunction

  // Each accepted event owns one flash start edge; queued ones chain PERIOD apart.
  task automatic model_edge(input logic ev, input logic clr);
    int last;
    exp_ovf = 1'b0;
    while (starts.size() > 0 && starts[0] + PERIOD <= edge_n) void'(starts.pop_front());
    if (clr) begin
      starts.delete();
    end else if (ev) begin
      last = (starts.size() > 0) ? starts[$] : -1000;
      if (edge_n >= last + PERIOD) starts.push_back(edge_n);
      else if (count_after(edge_n) >= MAX_P) exp_ovf = 1'b1;
      else starts.push_back(last + PERIOD);
    end
  endtask

  task automatic compute_expected();
    exp_led  = 1'b0;
    exp_busy = 1'b0;
    foreach (starts[i]) begin
      if (starts[i] <= edge_n && edge_n < starts[i] + ON_C)   exp_led  = 1'b1;
      if (starts[i] <= edge_n && edge_n < starts[i] + PERIOD) exp_busy = 1'b1;
    end
    exp_pend = 2'(count_after(edge_n));
  endtask

  task automatic checkOutput(input string tag);
    compute_expected();
    vectors += 4;
    assert (led === exp_led) else begin
      miscompares++;
      $error("[TB] FAIL %s led edge %0d: got %b expected %b", tag, edge_n, led, exp_led);
    end
    assert (busy === exp_busy) else begin
      miscompares++;
      $error("[TB] FAIL %s busy edge %0d: got %b expected %b", tag, edge_n, busy, exp_busy);
    end
    assert (pending === exp_pend) else begin
      miscompares++;
      $error("[TB] FAIL %s pending edge %0d: got %0d expected %0d", tag, edge_n, pending, exp_pend);
    end
    assert (overflow === exp_ovf) else begin
      miscompares++;
      $error("[TB] FAIL %s overflow edge %0d: got %b expected %b", tag, edge_n, overflow, exp_ovf);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic clr, input string tag);
    event_pulse = ev;
    clear       = clr;
    @(posedge clk);
    edge_n++;
    model_edge(ev, clr);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) applyStimulus(1'b0, 1'b0, tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    event_pulse = 1'b0;
    clear       = 1'b0;
    exp_ovf     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
    idle(3, "post_reset");

    applyStimulus(1'b1, 1'b0, "single");
    idle(10, "single");

    applyStimulus(1'b1, 1'b0, "three");
    idle(1, "three");
    applyStimulus(1'b1, 1'b0, "three");
    applyStimulus(1'b1, 1'b0, "three");
    idle(20, "three");

    repeat (6) applyStimulus(1'b1, 1'b0, "held");
    idle(30, "held");

    // Second event lands exactly on the GAP-end dequeue edge of the first replay.
    applyStimulus(1'b1, 1'b0, "deq_coincide");
    applyStimulus(1'b1, 1'b0, "deq_coincide");
    idle(PERIOD - 2, "deq_coincide");
    applyStimulus(1'b1, 1'b0, "deq_coincide");
    idle(20, "deq_coincide");

    applyStimulus(1'b1, 1'b0, "restart");
    idle(PERIOD - 1, "restart");
    applyStimulus(1'b1, 1'b0, "restart");
    idle(10, "restart");

    repeat (3) applyStimulus(1'b1, 1'b0, "clear");
    applyStimulus(1'b1, 1'b1, "clear");
    idle(10, "clear");

    applyStimulus(1'b1, 1'b0, "async_rst");
    idle(ON_C, "async_rst");
    #2 rst_n = 1'b0;
    starts.delete();
    #1 checkOutput("async_rst_low");
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    checkOutput("async_rst_low");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, "after_rst");
    idle(8, "after_rst");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 99) < 35), logic'($urandom_range(0, 99) < 3), "random");
    end
    idle(30, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
